// File: rtl/sevenseg_rx.sv
// -----------------------------------------------------------------------------
// sevenseg_rx
//
// Seven-segment pin-pattern receiver. It synchronizes the 12-pin display bus,
// waits until a pattern has stayed unchanged for STABLE_CYCLES edges, and then
// decodes the segment field back to a hex digit. The dp and digit-common pins
// are captured alongside the digit. Undecodable patterns are counted.
//
// Parameters
//   STABLE_CYCLES  edges a pattern must hold before acceptance (1..255)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   pins_in      [11:0] display pin bus, bit i = datasheet pin i+1 (async)
//   enable       1: track the bus, 0: hold outputs and restart on re-enable
//   clear_err    synchronous clear of err_count (wins over an increment)
//   digit_out    [3:0] last accepted decoded digit
//   dp_out       last accepted dp pin (pins_in[2])
//   commons_out  [3:0] last accepted {pins_in[11], [8], [7], [5]}
//   valid        last acceptance decoded successfully
//   invalid      last acceptance was not a legal segment code
//   update       one-cycle strobe: new decoded content was accepted
//   err_count    [7:0] invalid acceptances, saturating at 255
// -----------------------------------------------------------------------------
module sevenseg_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pins_in,
  input  logic        enable,
  input  logic        clear_err,
  output logic [3:0]  digit_out,
  output logic        dp_out,
  output logic [3:0]  commons_out,
  output logic        valid,
  output logic        invalid,
  output logic        update,
  output logic [7:0]  err_count
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [11:0] s1, s2, s3;
  logic        changed;
  logic        accept;

  logic [6:0]  seg;
  logic [3:0]  dec_digit;
  logic        dec_ok;
  logic [3:0]  commons;

  // s1/s2 form the synchronizer for the asynchronous bus; s3 is the previous
  // synchronized sample, so a change in s2 is seen one edge after it lands.
  // That extra stage gives the E + STABLE_CYCLES + 1 acceptance latency.
  // NOTE: every flop here, including the pin synchronizer, is reset to a
  // known value and written only with <=, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pins_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign changed = (s2 != s3);

  // Segment field, abcdefg order, and the digit-common pins.
  assign seg     = {s2[10], s2[6], s2[3], s2[1], s2[0], s2[9], s2[4]};
  assign commons = {s2[11], s2[8], s2[7], s2[5]};

  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'h0;
    unique case (seg)
      7'b1111110: dec_digit = 4'h0;
      7'b0110000: dec_digit = 4'h1;
      7'b1101101: dec_digit = 4'h2;
      7'b1111001: dec_digit = 4'h3;
      7'b0110011: dec_digit = 4'h4;
      7'b1011011: dec_digit = 4'h5;
      7'b1011111: dec_digit = 4'h6;
      7'b1110010: dec_digit = 4'h7;
      7'b1111111: dec_digit = 4'h8;
      7'b1111011: dec_digit = 4'h9;
      7'b1110111: dec_digit = 4'hA;
      7'b0011111: dec_digit = 4'hB;
      7'b1001110: dec_digit = 4'hC;
      7'b0111101: dec_digit = 4'hD;
      7'b1001111: dec_digit = 4'hE;
      7'b1000111: dec_digit = 4'hF;
      default:    dec_ok    = 1'b0;
    endcase
  end

  // Run-length FSM. The counter holds the number of edges the current s2
  // pattern has been unchanged (counting from re-enable after IDLE).
  // NOTE: all outputs of this block get a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          cnt_d = changed ? 8'd1 : cnt + 8'd1;
          if (cnt_d == STABLE_N) begin
            accept  = 1'b1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (changed) begin
            cnt_d = 8'd1;
            // A one-edge qualification accepts on the change edge itself.
            if (STABLE_N == 8'd1) accept = 1'b1;
            else                  state_d = SETTLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out   <= '0;
      dp_out      <= 1'b0;
      commons_out <= '0;
      valid       <= 1'b0;
      invalid     <= 1'b0;
      update      <= 1'b0;
      err_count   <= '0;
    end else begin
      update <= 1'b0;
      if (accept) begin
        if (dec_ok) begin
          // Only strobe when the visible content actually changes.
          update      <= !valid || (dec_digit != digit_out) ||
                         (s2[2] != dp_out) || (commons != commons_out);
          digit_out   <= dec_digit;
          dp_out      <= s2[2];
          commons_out <= commons;
          valid       <= 1'b1;
          invalid     <= 1'b0;
        end else begin
          valid   <= 1'b0;
          invalid <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
      if (clear_err) err_count <= '0;
    end
  end

endmodule
